ef_tmr_nch: RTL and testbench

Multi-channel, parametrised successor to the single-counter EF timer/PWM block. One prescaled W-bit counter (up, down or up/down) drives NCH independent compare channels. Each channel has a match pulse and a PWM output. Period and compare values are shadow-buffered and transferred only at update events. The block sits behind the bus register wrapper, like the existing timer, and feeds pads or motor-control logic.

---
 rtl/ef_tmr_nch_if.sv | 34 +++
 rtl/ef_tmr_nch.sv | 205 ++++++++++++++++++++
 tb/tb_ef_tmr_nch.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/ef_tmr_nch_if.sv
// Control, shadow-input and output signals of the multi-channel timer/PWM block.
// The master modport belongs to the register wrapper and the slave modport to the timer.
interface ef_tmr_nch_if #(
  parameter int W   = 16,
  parameter int NCH = 4,
  parameter int PRW = 8
);
  logic               en;
  logic [1:0]         mode;
  logic               one_shot;
  logic [PRW-1:0]     prescaler;
  logic [W-1:0]       period;
  logic [NCH*W-1:0]   cmp;
  logic               upd_req;
  logic [NCH-1:0]     ch_en;
  logic [NCH-1:0]     ch_pol;
  logic [7:0]         dt;
  logic [W-1:0]       cnt;
  logic               dir;
  logic               update_evt;
  logic [NCH-1:0]     match;
  logic [NCH-1:0]     pwm;
  logic [NCH-1:0]     pwm_n;

  modport master (
    output en, mode, one_shot, prescaler, period, cmp, upd_req, ch_en, ch_pol, dt,
    input  cnt, dir, update_evt, match, pwm, pwm_n
  );

  modport slave (
    input  en, mode, one_shot, prescaler, period, cmp, upd_req, ch_en, ch_pol, dt,
    output cnt, dir, update_evt, match, pwm, pwm_n
  );
endinterface

// File: rtl/ef_tmr_nch.sv
// Prescaled up/down/up-down counter with NCH shadow-buffered compare/PWM channels.
// Define EF_TMR_NCH_DEADTIME_EN to build per-channel dead-time insertion.
module ef_tmr_nch #(
  parameter int W   = 16,
  parameter int NCH = 4,
  parameter int PRW = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  ef_tmr_nch_if.slave  bus
);

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_DOWN = 2'b01,
    MODE_UP   = 2'b10,
    MODE_UPDN = 2'b11
  } mode_e;

  mode_e            mode;
  logic             en_q;
  logic [PRW-1:0]   pr_q, pr_d;
  logic             run_q, run_d;
  logic             pending_q, pending_d;
  logic [W-1:0]     per_a_q, per_a_d;
  logic [NCH*W-1:0] cmp_a_q, cmp_a_d;
  logic [W-1:0]     cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [NCH-1:0]   raw_q;
  logic [NCH-1:0]   raw_dt, rawn_dt;
  logic [NCH-1:0]   out_en;
  logic             start, tick, adv, wrap, upd_evt, xfer;

  assign mode    = mode_e'(bus.mode);
  assign start   = bus.en & ~en_q;
  assign tick    = bus.en & (pr_q == '0);
  // The start cycle only loads; counting begins on the following tick.
  assign adv     = tick & run_q & ~start;
  assign upd_evt = adv & wrap;
  assign xfer    = upd_evt & (pending_q | bus.upd_req);

  always_comb begin
    wrap = 1'b0;
    case (mode)
      MODE_UP:   wrap = (cnt_q >= per_a_q);
      MODE_DOWN: wrap = (cnt_q == '0);
      MODE_UPDN: wrap = ((cnt_q == '0) & ~dir_q) | (per_a_q == '0);
      MODE_HOLD: wrap = 1'b0;
    endcase
  end

  always_comb begin
    pr_d      = pr_q;
    run_d     = run_q;
    pending_d = pending_q | bus.upd_req;
    per_a_d   = per_a_q;
    cmp_a_d   = cmp_a_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;

    if (!bus.en || start || tick) pr_d = bus.prescaler;
    else                          pr_d = pr_q - 1'b1;

    if (start) begin
      run_d     = 1'b1;
      per_a_d   = bus.period;
      cmp_a_d   = bus.cmp;
      pending_d = 1'b0;
      cnt_d     = (mode == MODE_DOWN) ? bus.period : '0;
      dir_d     = (mode != MODE_DOWN);
    end else if (adv) begin
      if (xfer) begin
        per_a_d   = bus.period;
        cmp_a_d   = bus.cmp;
        pending_d = 1'b0;
      end
      // One-shot stops on its terminal value instead of wrapping.
      if (upd_evt && bus.one_shot) begin
        run_d = 1'b0;
      end else begin
        case (mode)
          MODE_UP: begin
            dir_d = 1'b1;
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
          end
          MODE_DOWN: begin
            dir_d = 1'b0;
            cnt_d = wrap ? per_a_d : cnt_q - 1'b1;
          end
          MODE_UPDN: begin
            if (per_a_q == '0) begin
              cnt_d = '0;
            end else if (dir_q) begin
              if (cnt_q >= per_a_q) begin
                dir_d = 1'b0;
                cnt_d = cnt_q - 1'b1;
              end else begin
                cnt_d = cnt_q + 1'b1;
              end
            end else if (cnt_q == '0) begin
              dir_d = 1'b1;
              cnt_d = cnt_q + 1'b1;
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
          MODE_HOLD: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q      <= 1'b0;
      pr_q      <= '0;
      run_q     <= 1'b0;
      pending_q <= 1'b0;
      per_a_q   <= '0;
      cmp_a_q   <= '0;
      cnt_q     <= '0;
      dir_q     <= 1'b1;
    end else begin
      en_q      <= bus.en;
      pr_q      <= pr_d;
      run_q     <= run_d;
      pending_q <= pending_d;
      per_a_q   <= per_a_d;
      cmp_a_q   <= cmp_a_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign bus.match[i] = adv & (cnt_q == cmp_a_q[i*W +: W]);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) raw_q[i] <= 1'b0;
      else        raw_q[i] <= (cnt_q < cmp_a_q[i*W +: W]);
    end
  end

`ifdef EF_TMR_NCH_DEADTIME_EN
  for (genvar i = 0; i < NCH; i++) begin : g_dt
    logic [7:0] on_cnt_q, off_cnt_q;
    logic       on_q, off_q;

    // Each side rises only after its input has been steady for dt cycles.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        on_cnt_q <= '0;
        on_q     <= 1'b0;
      end else if (!bus.en || !raw_q[i]) begin
        on_cnt_q <= '0;
        on_q     <= 1'b0;
      end else if (on_cnt_q >= bus.dt) begin
        on_q     <= 1'b1;
      end else begin
        on_cnt_q <= on_cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        off_cnt_q <= '0;
        off_q     <= 1'b0;
      end else if (!bus.en || raw_q[i]) begin
        off_cnt_q <= '0;
        off_q     <= 1'b0;
      end else if (off_cnt_q >= bus.dt) begin
        off_q     <= 1'b1;
      end else begin
        off_cnt_q <= off_cnt_q + 1'b1;
      end
    end

    assign raw_dt[i]  = on_q;
    assign rawn_dt[i] = off_q;
  end
`else
  logic [NCH-1:0] raw_dt_q, rawn_dt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_dt_q  <= '0;
      rawn_dt_q <= '0;
    end else begin
      raw_dt_q  <= raw_q;
      rawn_dt_q <= ~raw_q;
    end
  end

  assign raw_dt  = raw_dt_q;
  assign rawn_dt = rawn_dt_q;
`endif

  assign out_en         = {NCH{bus.en}} & bus.ch_en;
  assign bus.pwm        = bus.ch_pol ^ (raw_dt & out_en);
  assign bus.pwm_n      = bus.ch_pol ^ (rawn_dt & out_en);
  assign bus.cnt        = cnt_q;
  assign bus.dir        = dir_q;
  assign bus.update_evt = upd_evt;

endmodule

// File: tb/tb_ef_tmr_nch.sv
// Directed self-checking bench for ef_tmr_nch: counting modes, shadow transfer,
// one-shot, output forcing, asynchronous reset and (when built) dead time.
`timescale 1ns/1ps
module tb_ef_tmr_nch;
  localparam int W   = 16;
  localparam int NCH = 4;
  localparam int PRW = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ef_tmr_nch_if #(.W(W), .NCH(NCH), .PRW(PRW)) bus ();

  ef_tmr_nch #(.W(W), .NCH(NCH), .PRW(PRW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Stop the counter, load a setup, then raise en; returns on the start negedge.
  task automatic configure(input logic [1:0] m, input logic [7:0] psc,
                           input logic [15:0] per, input logic [63:0] c,
                           input logic os);
    @(negedge clk);
    bus.en        = 1'b0;
    bus.mode      = m;
    bus.prescaler = psc;
    bus.period    = per;
    bus.cmp       = c;
    bus.one_shot  = os;
    bus.upd_req   = 1'b0;
    repeat (2) @(negedge clk);
    bus.en = 1'b1;
  endtask

  task automatic test_reset();
    bus.en = 1'b0; bus.mode = 2'b10; bus.one_shot = 1'b0; bus.prescaler = '0;
    bus.period = '0; bus.cmp = '0; bus.upd_req = 1'b0; bus.ch_en = 4'hF;
    bus.ch_pol = 4'b1010; bus.dt = 8'd0;
    @(negedge clk);
    checks++; if (bus.cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", bus.cnt); end
    checks++; if (bus.dir !== 1'b1) begin errors++; $display("FAIL reset_dir got %b want 1", bus.dir); end
    checks++; if (bus.update_evt !== 1'b0 || bus.match !== 4'h0) begin errors++; $display("FAIL reset_pulses got evt=%b match=%b want 0/0000", bus.update_evt, bus.match); end
    checks++; if (bus.pwm !== 4'b1010 || bus.pwm_n !== 4'b1010) begin errors++; $display("FAIL reset_pwm got %b/%b want 1010/1010", bus.pwm, bus.pwm_n); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.ch_pol = 4'b0000;
  endtask

  task automatic test_up_mode();
    int exp_cnt [12] = '{0,1,2,3,4,0,1,2,3,4,0,1};
    bit exp_evt [12] = '{0,0,0,0,1,0,0,0,0,1,0,0};
    bit exp_m0  [12] = '{0,0,1,0,0,0,0,1,0,0,0,0};
    bit exp_pw  [12] = '{0,0,1,1,0,0,0,1,1,0,0,0};
    configure(2'b10, 8'd0, 16'd4, {16'd7, 16'd7, 16'd7, 16'd2}, 1'b0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checks++; if (bus.cnt !== 16'(exp_cnt[k])) begin errors++; $display("FAIL up_cnt k=%0d got %0d want %0d", k+1, bus.cnt, exp_cnt[k]); end
      checks++; if (bus.update_evt !== exp_evt[k]) begin errors++; $display("FAIL up_evt k=%0d got %b want %b", k+1, bus.update_evt, exp_evt[k]); end
      checks++; if (bus.match !== {3'b000, exp_m0[k]}) begin errors++; $display("FAIL up_match k=%0d got %b want %b", k+1, bus.match, {3'b000, exp_m0[k]}); end
      checks++; if (bus.pwm[0] !== exp_pw[k] || bus.pwm_n[0] !== !exp_pw[k]) begin errors++; $display("FAIL up_pwm0 k=%0d got %b/%b want %b/%b", k+1, bus.pwm[0], bus.pwm_n[0], exp_pw[k], !exp_pw[k]); end
      checks++; if (bus.dir !== 1'b1) begin errors++; $display("FAIL up_dir k=%0d got %b want 1", k+1, bus.dir); end
    end
  endtask

  task automatic test_updown();
    int exp_cnt [16] = '{0,0,1,1,2,2,3,3,2,2,1,1,0,0,1,1};
    bit exp_dir [16] = '{1,1,1,1,1,1,1,1,0,0,0,0,0,0,1,1};
    bit exp_evt [16] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,1,0,0};
    bit exp_m1  [16] = '{0,0,0,1,0,0,0,0,0,0,0,1,0,0,0,1};
    bit exp_pw  [16] = '{0,0,1,1,0,0,0,0,0,0,0,0,0,0,1,1};
    configure(2'b11, 8'd1, 16'd3, {16'd7, 16'd7, 16'd1, 16'd7}, 1'b0);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      checks++; if (bus.cnt !== 16'(exp_cnt[k])) begin errors++; $display("FAIL ud_cnt k=%0d got %0d want %0d", k+1, bus.cnt, exp_cnt[k]); end
      checks++; if (bus.dir !== exp_dir[k]) begin errors++; $display("FAIL ud_dir k=%0d got %b want %b", k+1, bus.dir, exp_dir[k]); end
      checks++; if (bus.update_evt !== exp_evt[k]) begin errors++; $display("FAIL ud_evt k=%0d got %b want %b", k+1, bus.update_evt, exp_evt[k]); end
      checks++; if (bus.match !== {2'b00, exp_m1[k], 1'b0}) begin errors++; $display("FAIL ud_match k=%0d got %b want %b", k+1, bus.match, {2'b00, exp_m1[k], 1'b0}); end
      if (k >= 2) begin
        checks++; if (bus.pwm[1] !== exp_pw[k]) begin errors++; $display("FAIL ud_pwm1 k=%0d got %b want %b", k+1, bus.pwm[1], exp_pw[k]); end
      end
    end
  endtask

  task automatic test_shadow();
    int exp_cnt [28] = '{0,1,2,3,4, 0,1,2,3,4,5,6,7,8, 0,1,2,3,4,5,6,7,8, 0,1,2,3, 0};
    bit exp_evt [28] = '{0,0,0,0,1, 0,0,0,0,0,0,0,0,1, 0,0,0,0,0,0,0,0,1, 0,0,0,1, 0};
    configure(2'b10, 8'd0, 16'd4, {16'd7, 16'd7, 16'd7, 16'd2}, 1'b0);
    for (int k = 0; k < 28; k++) begin
      @(negedge clk);
      checks++; if (bus.cnt !== 16'(exp_cnt[k])) begin errors++; $display("FAIL shadow_cnt k=%0d got %0d want %0d", k+1, bus.cnt, exp_cnt[k]); end
      checks++; if (bus.update_evt !== exp_evt[k]) begin errors++; $display("FAIL shadow_evt k=%0d got %b want %b", k+1, bus.update_evt, exp_evt[k]); end
      case (k + 1)
        3:  begin bus.period = 16'd8; bus.upd_req = 1'b1; end
        4:  bus.upd_req = 1'b0;
        10: bus.period = 16'd3;
        23: bus.upd_req = 1'b1;
        24: bus.upd_req = 1'b0;
        default: ;
      endcase
    end
  endtask

  task automatic test_one_shot();
    int exp_cnt [10] = '{5,4,3,2,1,0,0,0,0,0};
    bit exp_evt [10] = '{0,0,0,0,0,1,0,0,0,0};
    configure(2'b01, 8'd0, 16'd5, {16'd7, 16'd7, 16'd7, 16'd7}, 1'b1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++; if (bus.cnt !== 16'(exp_cnt[k])) begin errors++; $display("FAIL os_cnt k=%0d got %0d want %0d", k+1, bus.cnt, exp_cnt[k]); end
      checks++; if (bus.update_evt !== exp_evt[k]) begin errors++; $display("FAIL os_evt k=%0d got %b want %b", k+1, bus.update_evt, exp_evt[k]); end
      checks++; if (bus.dir !== 1'b0) begin errors++; $display("FAIL os_dir k=%0d got %b want 0", k+1, bus.dir); end
    end
    bus.en = 1'b0;
    @(negedge clk);
    bus.en = 1'b1;
    @(negedge clk);
    checks++; if (bus.cnt !== 16'd5) begin errors++; $display("FAIL os_restart0 got %0d want 5", bus.cnt); end
    @(negedge clk);
    checks++; if (bus.cnt !== 16'd4) begin errors++; $display("FAIL os_restart1 got %0d want 4", bus.cnt); end
    bus.one_shot = 1'b0;
  endtask

  task automatic test_edges();
    bus.ch_pol = 4'b0101;
    bus.ch_en  = 4'hF;
    configure(2'b10, 8'd0, 16'd4, {16'd0, 16'd5, 16'd5, 16'd0}, 1'b0);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++; if (bus.pwm !== 4'b0011) begin errors++; $display("FAIL edge_pwm k=%0d got %b want 0011", k, bus.pwm); end
      checks++; if (bus.pwm_n !== 4'b1100) begin errors++; $display("FAIL edge_pwm_n k=%0d got %b want 1100", k, bus.pwm_n); end
    end
    bus.ch_en = 4'h0;
    @(negedge clk);
    checks++; if (bus.pwm !== 4'b0101 || bus.pwm_n !== 4'b0101) begin errors++; $display("FAIL ch_en_off got %b/%b want 0101/0101", bus.pwm, bus.pwm_n); end
    bus.ch_en = 4'hF;
    bus.en    = 1'b0;
    @(negedge clk);
    checks++; if (bus.pwm !== 4'b0101 || bus.pwm_n !== 4'b0101) begin errors++; $display("FAIL en_off got %b/%b want 0101/0101", bus.pwm, bus.pwm_n); end
  endtask

  task automatic test_async_reset();
    bus.ch_pol = 4'b0110;
    configure(2'b10, 8'd0, 16'd4, {16'd7, 16'd7, 16'd7, 16'd7}, 1'b0);
    repeat (4) @(negedge clk);
    checks++; if (bus.cnt !== 16'd3 || bus.pwm[0] !== 1'b1) begin errors++; $display("FAIL pre_rst got cnt=%0d pwm0=%b want 3/1", bus.cnt, bus.pwm[0]); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.cnt !== 16'd0 || bus.dir !== 1'b1) begin errors++; $display("FAIL async_rst_cnt got %0d/%b want 0/1", bus.cnt, bus.dir); end
    checks++; if (bus.pwm !== 4'b0110 || bus.pwm_n !== 4'b0110) begin errors++; $display("FAIL async_rst_pwm got %b/%b want 0110/0110", bus.pwm, bus.pwm_n); end
    checks++; if (bus.update_evt !== 1'b0 || bus.match !== 4'h0) begin errors++; $display("FAIL async_rst_pulses got %b/%b want 0/0000", bus.update_evt, bus.match); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.ch_pol = 4'b0000;
  endtask

`ifdef EF_TMR_NCH_DEADTIME_EN
  task automatic test_dead_time();
    int both, hi, lo;
    bus.dt = 8'd3;
    configure(2'b10, 8'd0, 16'd19, {16'd7, 16'd7, 16'd7, 16'd10}, 1'b0);
    both = 0; hi = 0; lo = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (bus.pwm[0] && bus.pwm_n[0]) both++;
      if (k > 20 && bus.pwm[0]) hi++;
      if (k > 20 && bus.pwm_n[0]) lo++;
    end
    checks++; if (both !== 0) begin errors++; $display("FAIL dt3_overlap got %0d want 0", both); end
    checks++; if (hi !== 14) begin errors++; $display("FAIL dt3_pwm_high got %0d want 14", hi); end
    checks++; if (lo !== 14) begin errors++; $display("FAIL dt3_pwm_n_high got %0d want 14", lo); end
    bus.dt = 8'd12;
    configure(2'b10, 8'd0, 16'd19, {16'd7, 16'd7, 16'd7, 16'd10}, 1'b0);
    hi = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k > 20 && bus.pwm[0]) hi++;
    end
    checks++; if (hi !== 0) begin errors++; $display("FAIL dt12_pwm_high got %0d want 0", hi); end
    bus.dt = 8'd0;
  endtask
`else
  task automatic test_dead_time();
    bit exp_pw [10] = '{1,1,0,0,0,1,1,0,0,0};
    bus.dt = 8'd3;
    configure(2'b10, 8'd0, 16'd4, {16'd7, 16'd7, 16'd7, 16'd2}, 1'b0);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++; if (bus.pwm[0] !== exp_pw[k] || bus.pwm_n[0] !== !exp_pw[k]) begin errors++; $display("FAIL dt_ignored k=%0d got %b/%b want %b/%b", k+3, bus.pwm[0], bus.pwm_n[0], exp_pw[k], !exp_pw[k]); end
    end
    bus.dt = 8'd0;
  endtask
`endif

  initial begin
    test_reset();
    test_up_mode();
    test_updown();
    test_shadow();
    test_one_shot();
    test_edges();
    test_async_reset();
    test_dead_time();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
